// File: rtl/led_status_panel.sv
// Board LED panel: page 0 echoes the switches, pages 1..PAGES-1 show snapshotted CPU debug
// words. Optional PWM dimming (bright_i input) is enabled by defining LED_PWM_EN.
module led_status_panel #(
    parameter int unsigned LED_W     = 16,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned MODE_W    = 3,
    parameter int unsigned PAGES     = 4,
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned BLINK_MS  = 250,
    parameter int unsigned SCROLL_MS = 2000,
    parameter int unsigned PWM_W     = 4,
    localparam int unsigned PSW      = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
`ifdef LED_PWM_EN
    input  logic [PWM_W-1:0]               bright_i,
`endif
    input  logic                           run_i,
    input  logic [MODE_W-1:0]              mode_i,
    input  logic [ADDR_W-1:0]              in_addr_i,
    input  logic [(PAGES-1)*LED_W-1:0]     page_data_i,
    input  logic [PSW-1:0]                 page_sel_i,
    input  logic                           auto_scroll_i,
    input  logic                           freeze_i,
    output logic [LED_W-1:0]               leds_o,
    output logic [PSW-1:0]                 cur_page_o
);

    localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BlkW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
    localparam int unsigned ScrW = (SCROLL_MS > 1) ? $clog2(SCROLL_MS) : 1;
    localparam int unsigned AckW = $clog2(2 * BLINK_MS + 1);

    localparam logic [PreW-1:0] PreMax   = PreW'(TICK_DIV - 1);
    localparam logic [BlkW-1:0] BlkMax   = BlkW'(BLINK_MS - 1);
    localparam logic [ScrW-1:0] ScrMax   = ScrW'(SCROLL_MS - 1);
    localparam logic [AckW-1:0] AckLoad  = AckW'(2 * BLINK_MS);
    localparam logic [PSW-1:0]  LastPage = PSW'(PAGES - 1);

    if (LED_W < 1 + MODE_W + ADDR_W || PAGES < 2 || PAGES > 16 || PWM_W < 1 ||
        TICK_DIV < 1 || BLINK_MS < 1 || SCROLL_MS < 1) begin : g_param_err
        $error("led_status_panel: illegal parameter combination");
    end

    logic [PreW-1:0]                   presc_q, presc_d;
    logic [BlkW-1:0]                   blk_cnt_q, blk_cnt_d;
    logic                              blink_q, blink_d;
    logic [ScrW-1:0]                   scr_q, scr_d;
    logic [PSW-1:0]                    page_q, page_d;
    logic [PAGES-2:0][LED_W-1:0]       snap_q, snap_d;
    logic [MODE_W-1:0]                 mode_q;
    logic [AckW-1:0]                   ack_q, ack_d;
    logic [LED_W-1:0]                  leds_q;
    logic [LED_W-1:0]                  comp;
    logic [LED_W-1:0]                  page0_word;
    logic [PSW-1:0]                    page_idx;
    logic                              tick;

    assign tick       = (presc_q == PreMax);
    assign presc_d    = tick ? '0 : presc_q + 1'b1;
    assign snap_d     = freeze_i ? snap_q : page_data_i;
    assign page0_word = LED_W'({in_addr_i, mode_i, run_i});
    assign page_idx   = page_q - 1'b1;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        blink_d   = blink_q;
        if (tick) begin
            if (blk_cnt_q == BlkMax) begin
                blk_cnt_d = '0;
                blink_d   = ~blink_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end
    end

    // Manual mode follows page_sel (out-of-range selects fall back to page 0).
    always_comb begin
        page_d = page_q;
        scr_d  = scr_q;
        if (!auto_scroll_i) begin
            scr_d  = '0;
            page_d = (32'(page_sel_i) >= PAGES) ? '0 : page_sel_i;
        end else if (tick) begin
            if (scr_q == ScrMax) begin
                scr_d  = '0;
                page_d = (page_q == LastPage) ? '0 : page_q + 1'b1;
            end else begin
                scr_d = scr_q + 1'b1;
            end
        end
    end

    always_comb begin
        ack_d = ack_q;
        if (mode_i != mode_q) begin
            ack_d = AckLoad;
        end else if (tick && ack_q != '0) begin
            ack_d = ack_q - 1'b1;
        end
    end

    always_comb begin
        comp = (page_q == '0) ? page0_word : snap_q[page_idx];
        if (ack_q != '0) begin
            comp[MODE_W:1] = mode_i & {MODE_W{blink_q}};
        end
        if (!run_i) begin
            comp = LED_W'(blink_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q   <= '0;
            blk_cnt_q <= '0;
            blink_q   <= 1'b0;
            scr_q     <= '0;
            page_q    <= '0;
            snap_q    <= '0;
            mode_q    <= '0;
            ack_q     <= '0;
        end else begin
            presc_q   <= presc_d;
            blk_cnt_q <= blk_cnt_d;
            blink_q   <= blink_d;
            scr_q     <= scr_d;
            page_q    <= page_d;
            snap_q    <= snap_d;
            mode_q    <= mode_i;
            ack_q     <= ack_d;
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_q;
    logic [LED_W-1:0] comp_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_q  <= '0;
            comp_q <= '0;
            leds_q <= '0;
        end else begin
            pwm_q  <= pwm_q + 1'b1;
            comp_q <= comp;
            leds_q <= comp_q & {LED_W{pwm_q < bright_i}};
        end
    end
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            leds_q <= '0;
        end else begin
            leds_q <= comp;
        end
    end
`endif

    assign leds_o     = leds_q;
    assign cur_page_o = page_q;

endmodule
